param_delay_line: RTL
=====================

Name: param_delay_line

Overview:
- Parametrised, runtime-programmable delay line: the output equals the input sample from N enabled clock cycles earlier, with N selectable from 1 to MAX_DEPTH.
- Successor to the fixed two-cycle 8-bit delay register chain. Adds width and depth generics, per-sample valid tracking, a stall enable, flush, and a safe runtime delay change.
- Used to align data paths with different pipeline latencies in lab datapaths.

Parameters:
- WIDTH, 8, data bits per sample.
- MAX_DEPTH, 8, number of storage stages, which is the maximum delay; must be ≥ 2.
- DEFAULT_DELAY, 2, delay in effect after reset; legal range 1..MAX_DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 = stall (all stage contents held).
- flush  input  1  synchronous; clears all valid bits.
- delay_sel  input  DEPTH_W  requested delay, where DEPTH_W = $clog2(MAX_DEPTH+1).
- d_valid  input  1  the input sample is valid.
- d  input  WIDTH  input sample.
- q_valid  output  1  the output sample is valid.
- q  output  WIDTH  delayed sample.
- delay_active  output  DEPTH_W  delay currently in effect.

Behaviour:
- Reset (async, rst=1):
  - all stage data = 0; all stage valid bits = 0.
  - delay_active = DEFAULT_DELAY; q = 0; q_valid = 0.
- Storage: MAX_DEPTH stages, each holding a WIDTH-bit data field and a 1-bit valid field.
- On a rising edge with en=1:
  - stage[0] <= {d_valid, d}.
  - stage[i] <= stage[i-1] for i = 1..MAX_DEPTH-1.
- On a rising edge with en=0: the data and valid bits of every stage are held.
- Output tap:
  - q = stage[delay_active-1].data; q_valid = stage[delay_active-1].valid.
  - The tap is a combinational mux from registers, with no extra register stage.
- Latency: a sample presented at edge k, with en=1 on every edge, appears on q after edge k+delay_active-1. That is, it is visible for the cycle following exactly delay_active enabled edges.
  - Example with delay 2: inputs 1, 2, 3, … give q = x, x, 1, 2, 3, …
- Delay clamp, applied to delay_sel before it is compared or latched:
  - delay_sel = 0 → clamped to 1.
  - delay_sel > MAX_DEPTH → clamped to MAX_DEPTH.
- Delay change: on any edge where clamp(delay_sel) ≠ delay_active:
  - delay_active <= clamp(delay_sel).
  - All valid bits are cleared, including the one being shifted in on that edge. This prevents old samples from being misaligned.
  - Data fields shift or hold normally.
  - The change takes effect regardless of en.
- flush=1 on an edge:
  - all valid bits are cleared, including the incoming d_valid; data shifts or holds normally per en.
  - flush also acts regardless of en.
- Precedence: rst > (flush or delay change: clear valids) > normal shift.
- Priming: after a flush, a delay change or reset, q_valid stays 0 until delay_active valid samples have been accepted.
- Stall mid-stream: with en=0, q and q_valid are constant, and no sample is lost or duplicated.
- An async rst asserted mid-operation takes effect immediately, independent of clk.
- Implementation constraints:
  - No latches, no combinational loop from input to output.
  - q does not depend combinationally on d; it depends combinationally on the registered delay_active only.

Decomposition:
- Shared package (delay_pkg):
  - the DEPTH_W derivation function (clog2 wrapper);
  - the clamp function for delay_sel.
- One sub-module, delay_stage:
  - a single WIDTH+1-bit register with en, valid-clear and async rst;
  - instantiated MAX_DEPTH times in a generate loop.
- Tap mux and delay-control logic live in the top level.

Test Plan:
1. Reset, then delay_sel=2, en=1, d_valid=1, d=1,2,3,4,5 on consecutive edges → q_valid=0 for the first two output cycles, then q=1,2,3 with q_valid=1.
2. delay_sel=MAX_DEPTH (8), stream d=10..30 → first valid q=10 exactly 8 enabled edges after it is applied; delay_sel=9 and delay_sel=0 → delay_active reads 8 and 1 respectively.
3. Stream with delay 3, drop en for 4 cycles mid-stream → q and q_valid frozen during the stall; sequence resumes with no gaps or duplicates.
4. Stream with delay 2, change delay_sel to 5 → delay_active=5 on the next edge; q_valid=0 for the next 5 accepted samples; then output is correctly 5-delayed.
5. flush pulse coincident with d_valid=1, d=0xAA → 0xAA never appears with q_valid=1; the following samples prime normally.
6. Assert rst asynchronously between edges while q_valid=1 → q=0, q_valid=0, delay_active=DEFAULT_DELAY immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared helpers for the parametrised delay line: select-width derivation and
// clamping of the requested delay into the legal 1..max_depth range.
package delay_pkg;

  function automatic int depth_w(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int clamp_delay(input int sel, input int max_depth);
    if (sel < 1) begin
      return 1;
    end
    if (sel > max_depth) begin
      return max_depth;
    end
    return sel;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One storage stage of the delay line: a data field plus a valid bit.
// clr_valid clears the valid bit whether or not the stage advances.
module delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_valid,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d,
  output logic             q_valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      if (en) begin
        q       <= d;
        q_valid <= d_valid & ~clr_valid;
      end else begin
        q_valid <= q_valid & ~clr_valid;
      end
    end
  end

endmodule

// File: rtl/param_delay_line.sv
// Runtime-programmable delay line: q is the sample accepted delay_active
// enabled edges earlier, tapped combinationally from the stage registers.
module param_delay_line
  import delay_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MAX_DEPTH     = 8,
  parameter int DEFAULT_DELAY = 2,
  localparam int DEPTH_W      = depth_w(MAX_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic [DEPTH_W-1:0] delay_sel,
  input  logic               d_valid,
  input  logic [WIDTH-1:0]   d,
  output logic               q_valid,
  output logic [WIDTH-1:0]   q,
  output logic [DEPTH_W-1:0] delay_active
);

  // Valid semantics: d_valid qualifies d only on edges with en=1; q_valid
  // qualifies q in the same cycle. There is no backpressure in either direction.

  logic [DEPTH_W-1:0]   sel_clamped;
  logic                 change;
  logic                 clr_valid;
  logic [WIDTH-1:0]     stage_data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] stage_valid;

  assign sel_clamped = DEPTH_W'(clamp_delay(int'(delay_sel), MAX_DEPTH));
  assign change      = (sel_clamped != delay_active);
  // A new delay would misalign in-flight samples, so it drops them like a flush.
  assign clr_valid   = flush | change;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_active <= DEPTH_W'(DEFAULT_DELAY);
    end else if (change) begin
      delay_active <= sel_clamped;
    end
  end

  for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic             in_valid;

    if (i == 0) begin : g_head
      assign in_data  = d;
      assign in_valid = d_valid;
    end else begin : g_body
      assign in_data  = stage_data[i-1];
      assign in_valid = stage_valid[i-1];
    end

    delay_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr_valid(clr_valid),
      .d_valid  (in_valid),
      .d        (in_data),
      .q_valid  (stage_valid[i]),
      .q        (stage_data[i])
    );
  end

  always_comb begin
    q       = '0;
    q_valid = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (delay_active == DEPTH_W'(i + 1)) begin
        q       = stage_data[i];
        q_valid = stage_valid[i];
      end
    end
  end

endmodule
